// File: rtl/sseg_pkg.sv
// Shared types and segment patterns for the seven-segment scan controller.
// Patterns are active-low {g,f,e,d,c,b,a}; sseg_t adds the decimal point as bit 7.
package sseg_pkg;

  typedef logic [7:0] sseg_t;
  typedef logic [3:0] nibble_t;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Non-decimal nibbles cannot come out of the BCD engine; show them blank.
  function automatic logic [6:0] seg_decode(input nibble_t n);
    logic [6:0] s;
    case (n)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble converter: one input bit per cycle, VALUE_W cycles per value.
// o_done/o_bcd are valid together in the cycle whose clock edge finishes the conversion.
module bin2bcd_serial
  import sseg_pkg::*;
#(
  parameter int VALUE_W = 14,
  parameter int NIBBLES = 5
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic [VALUE_W-1:0]     i_value,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [NIBBLES*4-1:0]   o_bcd
);

  localparam int CNT_W = $clog2(VALUE_W + 1);

  logic                 r_busy;
  logic [CNT_W-1:0]     r_cnt;
  logic [VALUE_W-1:0]   r_bin;
  logic [NIBBLES*4-1:0] r_bcd;
  logic [NIBBLES*4-1:0] w_bcd_next;
  nibble_t              w_nib;
  logic                 w_carry;

  // Add-3 correction on every nibble, then shift the next binary MSB in.
  always_comb begin
    w_bcd_next = '0;
    w_nib      = '0;
    w_carry    = r_bin[VALUE_W-1];
    for (int i = 0; i < NIBBLES; i++) begin
      w_nib = r_bcd[4*i +: 4];
      if (w_nib >= 4'd5) w_nib = w_nib + 4'd3;
      w_bcd_next[4*i +: 4] = {w_nib[2:0], w_carry};
      w_carry = w_nib[3];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= CNT_W'(VALUE_W);
    end else if (r_busy) begin
      r_cnt <= r_cnt - CNT_W'(1);
      if (r_cnt == CNT_W'(1)) r_busy <= 1'b0;
    end
  end

  // Working registers carry no reset; they are reloaded on every start.
  always_ff @(posedge i_clk) begin
    if (i_start) begin
      r_bin <= i_value;
      r_bcd <= '0;
    end else if (r_busy) begin
      r_bin <= {r_bin[VALUE_W-2:0], 1'b0};
      r_bcd <= w_bcd_next;
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_busy && (r_cnt == CNT_W'(1));
  assign o_bcd  = w_bcd_next;

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Seven-segment scan controller: binary value -> BCD -> multiplexed common-anode digits.
// Optional brightness dimming via the `duty` port when SSEG_DIMMING_EN is defined.
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int VALUE_W     = 14,
  parameter int REFRESH_DIV = 100000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [VALUE_W-1:0] value,
  input  logic               load,
  input  logic               blank_lz,
  input  logic [DIGITS-1:0]  dp_in,
`ifdef SSEG_DIMMING_EN
  input  logic [3:0]         duty,
`endif
  output logic [DIGITS-1:0]  an,
  output sseg_t              sseg,
  output logic               busy,
  output logic               overflow
);

  localparam int NIBBLES = DIGITS + 1;
  localparam int PRE_W   = $clog2(REFRESH_DIV);
  localparam int IDX_W   = $clog2(DIGITS);

  logic                 w_eng_busy;
  logic                 w_eng_done;
  logic                 w_start;
  logic [VALUE_W-1:0]   w_start_val;
  logic [NIBBLES*4-1:0] w_bcd;

  logic                 r_pend_vld;
  logic [VALUE_W-1:0]   r_pend_val;
  logic [DIGITS*4-1:0]  r_disp;
  logic                 r_ovf;
  logic [PRE_W-1:0]     r_presc;
  logic [IDX_W-1:0]     r_idx;
  logic [DIGITS-1:0]    r_an;
  sseg_t                r_sseg;

  nibble_t              w_nib;
  logic                 w_dp;
  logic                 w_lz;
  logic                 w_zero;
  logic                 w_zero_above;
  logic [DIGITS-1:0]    w_an_sel;
  sseg_t                w_seg;
  logic                 w_on;

  // A load at the completing edge wins over the held pending value.
  always_comb begin
    w_start     = 1'b0;
    w_start_val = value;
    if (!w_eng_busy) begin
      w_start = load;
    end else if (w_eng_done) begin
      w_start = load | r_pend_vld;
      if (!load) w_start_val = r_pend_val;
    end
  end

  bin2bcd_serial #(
    .VALUE_W (VALUE_W),
    .NIBBLES (NIBBLES)
  ) u_bcd (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_start (w_start),
    .i_value (w_start_val),
    .o_busy  (w_eng_busy),
    .o_done  (w_eng_done),
    .o_bcd   (w_bcd)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend_vld <= 1'b0;
      r_pend_val <= '0;
      r_disp     <= '0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_eng_busy && !w_eng_done && load) begin
        r_pend_vld <= 1'b1;
        r_pend_val <= value;
      end else if (w_eng_done) begin
        r_pend_vld <= 1'b0;
      end
      if (w_eng_done) begin
        r_disp <= w_bcd[DIGITS*4-1:0];
        r_ovf  <= |w_bcd[NIBBLES*4-1 -: 4];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (r_presc == PRE_W'(REFRESH_DIV - 1)) begin
      r_presc <= '0;
      r_idx   <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
    end else begin
      r_presc <= r_presc + PRE_W'(1);
    end
  end

  // Walk from the top digit down so each digit knows whether everything above it is zero.
  always_comb begin
    w_nib        = '0;
    w_dp         = 1'b0;
    w_lz         = 1'b0;
    w_an_sel     = '1;
    w_zero       = 1'b1;
    w_zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_zero = w_zero_above && (r_disp[4*i +: 4] == 4'd0);
      if (r_idx == IDX_W'(i)) begin
        w_nib       = r_disp[4*i +: 4];
        w_dp        = dp_in[i];
        w_lz        = w_zero && (i != 0);
        w_an_sel[i] = 1'b0;
      end
      w_zero_above = w_zero;
    end
  end

  always_comb begin
    if (r_ovf)
      w_seg = {1'b1, SEG_DASH};
    else if (blank_lz && w_lz)
      w_seg = {~w_dp, SEG_BLANK};
    else
      w_seg = {~w_dp, seg_decode(w_nib)};
  end

`ifdef SSEG_DIMMING_EN
  localparam int SLICE = REFRESH_DIV / 16;
  localparam int LIM_W = PRE_W + 1;

  // Anode on-window is (duty+1) sixteenths of the slot, measured from slot start.
  always_comb begin
    w_on = ({1'b0, r_presc} < LIM_W'((32'(duty) + 32'd1) * SLICE));
  end
`else
  always_comb begin
    w_on = 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_an   <= '1;
      r_sseg <= 8'hFF;
    end else begin
      r_an   <= w_on ? w_an_sel : '1;
      r_sseg <= w_seg;
    end
  end

  assign an       = r_an;
  assign sseg     = r_sseg;
  assign busy     = w_eng_busy;
  assign overflow = r_ovf;

endmodule

// File: doc/sseg_scan_ctrl.md
# sseg_scan_ctrl

Parametrised seven-segment scan controller for the board display: takes a binary value (game score), converts it to BCD with a serial double-dabble engine, and time-multiplexes DIGITS common-anode digits. Adds leading-zero blanking, overflow indication and optional brightness dimming. Sits beside the VGA pipeline in the top level, fed from the score counter, driving `an`/`seg`/`dp` pins.

## Interface
- `DIGITS`, 4: number of digits scanned (2..8)
- `VALUE_W`, 14: width of binary input value
- `REFRESH_DIV`, 100000: clk cycles per digit slot (≥16, multiple of 16)

- `clk` in 1: system clock
- `rst` in 1: asynchronous, active-low reset
- `value` in VALUE_W: binary value to display
- `load` in 1: one-cycle strobe, capture `value`
- `blank_lz` in 1: 1 = blank leading zeros
- `dp_in` in DIGITS: decimal point per digit, 1 = lit
- `duty` in 4: brightness, present only with SSEG_DIMMING_EN
- `an` out DIGITS: anodes, active-low, one-cold
- `sseg` out 8: {dp,g,f,e,d,c,b,a}, active-low
- `busy` out 1: conversion in progress
- `overflow` out 1: displayed value ≥ 10^DIGITS

## Operation
- Conversion: `load` with `busy`=0 captures `value`; shift-add-3 over DIGITS+1 BCD nibbles, one bit per cycle, VALUE_W cycles. On completion, low DIGITS nibbles go to display register; `overflow` = (top nibble ≠ 0).
- `load` while `busy`=1: value held as pending (last wins); new conversion starts the cycle after current one ends; `busy` stays high throughout.
- Display register changes only at conversion completion; scan never shows partial results.
- Scan: prescaler 0..REFRESH_DIV-1; at wrap, digit index increments mod DIGITS (0 = rightmost, `an[0]`).
- Segment decode per nibble 0..9: 0x40,0x79,0x24,0x30,0x19,0x12,0x02,0x78,0x00,0x10 (`sseg[6:0]`); blank = 0x7F; dash = 0x3F.
- Leading-zero blanking: with `blank_lz`=1, digits above the most significant nonzero digit show blank; digit 0 never blanked. `dp` still follows `dp_in`.
- Overflow: all digits show dash, `dp` off, regardless of `blank_lz`.
- `sseg[7]` = ~`dp_in[index]`.

## Timing
- Reset values: `an`='1, `sseg`=8'hFF, `busy`=0, `overflow`=0, display register 0, index 0, prescaler 0, pending cleared.
- `load` accepted at edge N: `busy`=1 from N+1 through N+VALUE_W; display register and `overflow` update at edge N+VALUE_W; `busy`=0 from N+VALUE_W+1 unless pending.
- `an`/`sseg` registered: one cycle after index/prescaler change.
- First digit-0 enable one cycle after reset release.
- Reset mid-conversion: conversion and pending aborted, display returns to 0.

## Configuration
- `SSEG_DIMMING_EN` defined: `duty` port exists; within each slot the anode is enabled only while prescaler < (duty+1)·REFRESH_DIV/16 (duty=15 = full); `sseg` unchanged.
- Undefined: no `duty` port; anode enabled for the whole slot.

## Structure
- Package `sseg_pkg`: segment pattern constants (digits 0–9, blank, dash), `sseg_t` typedef (8-bit), nibble typedef.
- Sub-module `bin2bcd_serial`: parametrised (VALUE_W, nibble count) start/busy/done double-dabble engine; scan, blanking, pending logic stay in top.

## Test plan
(DIGITS=4, VALUE_W=14, REFRESH_DIV=16)
- Reset: `an`=4'b1111, `sseg`=8'hFF, `busy`=0; after release digit 0 enabled with `sseg[6:0]`=0x40.
- `load` 1234 → `busy` high 14 cycles; then digits 0..3 show 0x19,0x30,0x24,0x79, each 16 cycles, `an` 1110,1101,1011,0111.
- `blank_lz`=1, `load` 7 → digit 0 0x78, digits 1..3 0x7F; `dp_in`=4'b0100 → digit 2 `sseg`=8'h7F.
- `load` 12000 → `overflow`=1, all digits 0x3F, `sseg[7]`=1.
- `load` 5, then `load` 8 and `load` 9 while busy → `busy` high 28 cycles continuous, final display 9; reset asserted at cycle 5 of another conversion → all outputs at reset values, nothing displayed afterwards but 0.
- With SSEG_DIMMING_EN, `duty`=3 → each anode low exactly 4 of 16 slot cycles; `duty`=15 → 16 of 16.
